// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing generator with a clock-enable pixel divider (no derived clock).
// Latency : every decoded output is a flop loaded on the tick edge from the next counter values.
// Flow    : no backpressure; enable low freezes the divider, counters and outputs, and forces pix_ce low.
//
// Ports:
//   clk_50MHz          system clock, all state on the rising edge
//   clear              asynchronous active-low reset
//   enable             run when high, freeze when low
//   pix_ce             one-cycle strobe in the first cycle of each new pixel position
//   h_count / v_count  current pixel x / line y
//   h_sync / v_sync    syncs at H_SYNC_POL / V_SYNC_POL active level
//   de, vblank         visible-area enable, vertical blanking
//   line_start         high for the whole pixel period of h_count==0
//   frame_start        high for the whole pixel period of (0,0)
//   frame_count        frames started since reset minus one (wraps)
module vga_timing_gen #(
    parameter int H_DISP       = 640,
    parameter int H_FP         = 16,
    parameter int H_PW         = 96,
    parameter int H_BP         = 48,
    parameter int V_DISP       = 480,
    parameter int V_FP         = 10,
    parameter int V_PW         = 2,
    parameter int V_BP         = 29,
    parameter int CLK_DIV      = 2,
    parameter bit H_SYNC_POL   = 1'b0,
    parameter bit V_SYNC_POL   = 1'b0,
    parameter int COUNTER_BITS = 16,
    parameter int FRAME_BITS   = 8
) (
    input  logic                    clk_50MHz,
    input  logic                    clear,
    input  logic                    enable,
    output logic                    pix_ce,
    output logic [COUNTER_BITS-1:0] h_count,
    output logic [COUNTER_BITS-1:0] v_count,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    de,
    output logic                    vblank,
    output logic                    line_start,
    output logic                    frame_start,
    output logic [FRAME_BITS-1:0]   frame_count
);

    localparam int H_TOTAL = H_DISP + H_FP + H_PW + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_PW + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic [COUNTER_BITS-1:0] cnt_t;

    localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_DISP_C     = cnt_t'(H_DISP);
    localparam cnt_t V_DISP_C     = cnt_t'(V_DISP);
    localparam cnt_t H_SYNC_START = cnt_t'(H_DISP + H_FP);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_DISP + H_FP + H_PW);
    localparam cnt_t V_SYNC_START = cnt_t'(V_DISP + V_FP);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_DISP + V_FP + V_PW);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Elaboration-time sanity checks on the parameter set.
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if ($clog2(H_TOTAL) > COUNTER_BITS || $clog2(V_TOTAL) > COUNTER_BITS) begin : g_bad_counter_bits
        $error("vga_timing_gen: COUNTER_BITS too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    cnt_t             h_next;
    cnt_t             v_next;
    logic             h_sync_region;
    logic             v_sync_region;

    // With CLK_DIV=1 DIV_LAST is 0 and div never leaves 0, so every enabled edge ticks.
    assign tick = enable && (div == DIV_LAST);

    // Next raster position; the decoded flops are loaded from these so they
    // always agree with the counters they are loaded alongside.
    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_wrap = (v_count == V_LAST);
        h_next = h_wrap ? '0 : h_count + cnt_t'(1);
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_count + cnt_t'(1);
        end
        h_sync_region = (h_next >= H_SYNC_START) && (h_next < H_SYNC_END);
        v_sync_region = (v_next >= V_SYNC_START) && (v_next < V_SYNC_END);
    end

    // Reset parks the raster on the last pixel of the last line so the first
    // tick lands on (0,0) and rolls frame_count from all-ones to zero.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            frame_count <= '1;
            h_sync      <= ~H_SYNC_POL;
            v_sync      <= ~V_SYNC_POL;
            de          <= 1'b0;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_ce <= tick;
            if (enable) begin
                div <= tick ? '0 : div + DIV_W'(1);
            end
            if (tick) begin
                h_count <= h_next;
                v_count <= v_next;
                if (h_wrap && v_wrap) begin
                    frame_count <= frame_count + FRAME_BITS'(1);
                end
                h_sync      <= h_sync_region ? H_SYNC_POL : ~H_SYNC_POL;
                v_sync      <= v_sync_region ? V_SYNC_POL : ~V_SYNC_POL;
                de          <= (h_next < H_DISP_C) && (v_next < V_DISP_C);
                vblank      <= (v_next >= V_DISP_C);
                line_start  <= (h_next == '0);
                frame_start <= (h_next == '0) && (v_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : self-checking bench for vga_timing_gen using two small-raster instances.
// Latency : expectations sampled 1 time unit after each rising clock edge.
// Flow    : a shared enable/clear drive both instances; a tick-count model predicts every output.
module tb_vga_timing_gen;

    // Instance A: CLK_DIV=3, active-low syncs, H 16/4/6/5 (31), V 8/2/3/2 (15), 3-bit frame counter.
    // Instance B: CLK_DIV=1, active-high syncs, H 8/2/2/2 (14), V 4/1/1/1 (7), 4-bit counters.
    localparam int A_FRAME_TICKS = 31 * 15;

    logic clk;
    logic clear;
    logic enable;

    logic        a_pix_ce, a_h_sync, a_v_sync, a_de, a_vblank, a_line_start, a_frame_start;
    logic [15:0] a_h_count, a_v_count;
    logic [2:0]  a_frame_count;

    logic        b_pix_ce, b_h_sync, b_v_sync, b_de, b_vblank, b_line_start, b_frame_start;
    logic [3:0]  b_h_count, b_v_count;
    logic [3:0]  b_frame_count;

    vga_timing_gen #(
        .H_DISP(16), .H_FP(4), .H_PW(6), .H_BP(5),
        .V_DISP(8), .V_FP(2), .V_PW(3), .V_BP(2),
        .CLK_DIV(3), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .COUNTER_BITS(16), .FRAME_BITS(3)
    ) dut_a (
        .clk_50MHz(clk), .clear(clear), .enable(enable),
        .pix_ce(a_pix_ce), .h_count(a_h_count), .v_count(a_v_count),
        .h_sync(a_h_sync), .v_sync(a_v_sync), .de(a_de), .vblank(a_vblank),
        .line_start(a_line_start), .frame_start(a_frame_start), .frame_count(a_frame_count)
    );

    vga_timing_gen #(
        .H_DISP(8), .H_FP(2), .H_PW(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
        .CLK_DIV(1), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .COUNTER_BITS(4), .FRAME_BITS(4)
    ) dut_b (
        .clk_50MHz(clk), .clear(clear), .enable(enable),
        .pix_ce(b_pix_ce), .h_count(b_h_count), .v_count(b_v_count),
        .h_sync(b_h_sync), .v_sync(b_v_sync), .de(b_de), .vblank(b_vblank),
        .line_start(b_line_start), .frame_start(b_frame_start), .frame_count(b_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pce;
        logic [15:0] h;
        logic [15:0] v;
        logic [7:0]  fr;
        logic        hs;
        logic        vs;
        logic        de;
        logic        vb;
        logic        ls;
        logic        fs;
    } obs_t;

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint en_cnt = 0;   // enabled, out-of-reset clock edges since the last reset
    bit     last_en = 1'b0;

    // Reference: the raster position is simply (ticks-1) laid out row-major over
    // H_TOTAL x V_TOTAL, where ticks = enabled edges / CLK_DIV.
    function automatic obs_t model(input longint ecnt, input bit len, input int cdiv,
                                   input int hd, input int hf, input int hp, input int hb,
                                   input int vd, input int vf, input int vp, input int vb,
                                   input int fb, input bit hpol, input bit vpol);
        obs_t   e;
        longint ticks, p, h, v, ht, vt;
        ht    = hd + hf + hp + hb;
        vt    = vd + vf + vp + vb;
        ticks = ecnt / cdiv;
        e     = '0;
        e.pce = len && (ecnt > 0) && ((ecnt % cdiv) == 0);
        if (ticks == 0) begin
            e.h  = 16'(ht - 1);
            e.v  = 16'(vt - 1);
            e.fr = 8'((1 << fb) - 1);
            e.hs = ~hpol;
            e.vs = ~vpol;
            e.de = 1'b0;
            e.vb = 1'b1;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end else begin
            p    = ticks - 1;
            h    = p % ht;
            v    = (p / ht) % vt;
            e.h  = 16'(h);
            e.v  = 16'(v);
            e.fr = 8'((p / (ht * vt)) % (longint'(1) << fb));
            e.hs = (h >= hd + hf && h < hd + hf + hp) ? hpol : ~hpol;
            e.vs = (v >= vd + vf && v < vd + vf + vp) ? vpol : ~vpol;
            e.de = (h < hd) && (v < vd);
            e.vb = (v >= vd);
            e.ls = (h == 0);
            e.fs = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_dut(input string n, input obs_t o, input obs_t e);
        check({n, ".pix_ce"},      o.pce, e.pce);
        check({n, ".h_count"},     o.h,   e.h);
        check({n, ".v_count"},     o.v,   e.v);
        check({n, ".frame_count"}, o.fr,  e.fr);
        check({n, ".h_sync"},      o.hs,  e.hs);
        check({n, ".v_sync"},      o.vs,  e.vs);
        check({n, ".de"},          o.de,  e.de);
        check({n, ".vblank"},      o.vb,  e.vb);
        check({n, ".line_start"},  o.ls,  e.ls);
        check({n, ".frame_start"}, o.fs,  e.fs);
    endtask

    task automatic compare_all();
        obs_t oa, ob;
        oa = '{a_pix_ce, a_h_count, a_v_count, 8'(a_frame_count), a_h_sync, a_v_sync,
               a_de, a_vblank, a_line_start, a_frame_start};
        ob = '{b_pix_ce, 16'(b_h_count), 16'(b_v_count), 8'(b_frame_count), b_h_sync, b_v_sync,
               b_de, b_vblank, b_line_start, b_frame_start};
        compare_dut("A", oa, model(en_cnt, last_en, 3, 16, 4, 6, 5, 8, 2, 3, 2, 3, 1'b0, 1'b0));
        compare_dut("B", ob, model(en_cnt, last_en, 1, 8, 2, 2, 2, 4, 1, 1, 1, 4, 1'b1, 1'b1));
    endtask

    // Called 1 time unit after a rising edge: drive enable, take one edge, then check.
    task automatic step(input bit en);
        enable = en;
        @(posedge clk);
        if (clear) begin
            last_en = en;
            if (en) en_cnt++;
        end else begin
            last_en = 1'b0;
        end
        #1;
        compare_all();
    endtask

    initial begin
        bit found;
        clear  = 1'b0;
        enable = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("A.reset_h_count", a_h_count, 30);
        check("B.reset_h_sync", b_h_sync, 0);

        // Release with enable high: first pixel of A lands on the third edge.
        clear = 1'b1;
        step(1'b1);
        step(1'b1);
        check("A.pix_ce_before_first_tick", a_pix_ce, 0);
        step(1'b1);
        check("A.first_pix_ce", a_pix_ce, 1);
        check("A.first_h", a_h_count, 0);
        check("A.first_v", a_v_count, 0);
        check("A.first_frame_start", a_frame_start, 1);
        check("A.first_frame_count", a_frame_count, 0);
        check("A.first_de", a_de, 1);

        // Random enable run.
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 3) != 0);

        // Freeze at h_count=10 for 5 clocks, mid divider count.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1'b1);
            found = (a_h_count == 10) && a_pix_ce;
        end
        check("A.wait_h10", found, 1);
        step(1'b1);
        repeat (5) step(1'b0);
        check("A.frozen_h", a_h_count, 10);
        check("A.frozen_pix_ce", a_pix_ce, 0);
        step(1'b1);
        check("A.resume_no_early_tick", a_h_count, 10);
        step(1'b1);
        check("A.resume_h", a_h_count, 11);
        check("A.resume_pix_ce", a_pix_ce, 1);

        // Run until A has wrapped its 3-bit frame counter back to 0.
        for (int i = 0; i < 40000 && (en_cnt / 3) < 8 * A_FRAME_TICKS + 1; i++) begin
            step($urandom_range(0, 3) != 0);
        end
        check("A.wrap_frame_count", a_frame_count, 0);
        check("A.wrap_frame_start", a_frame_start, 1);
        check("A.wrap_h", a_h_count, 0);

        // Asynchronous clear while A is inside h_sync.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step(1'b1);
            found = (a_h_count >= 22) && (a_h_count <= 24) && (a_v_count == 5);
        end
        check("A.wait_in_hsync", found, 1);
        check("A.in_hsync_active", a_h_sync, 0);
        #2;
        clear = 1'b0;
        #1;
        en_cnt  = 0;
        last_en = 1'b0;
        compare_all();
        check("A.clear_h_sync", a_h_sync, 1);
        check("A.clear_de", a_de, 0);
        check("A.clear_v", a_v_count, 14);
        @(posedge clk);
        #1;
        step(1'b1);
        compare_all();
        clear = 1'b1;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("A.restart_h", a_h_count, 0);
        check("A.restart_frame_count", a_frame_count, 0);

        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
